// File: rtl/comp_chan_scheduler_pkg.sv
// Shared types and widths for the stereo compression-core scheduler.
package comp_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_L,
    ISSUE_R,
    DRAIN,
    HOLD
  } state_t;

  localparam logic CHAN_L     = 1'b0;
  localparam logic CHAN_R     = 1'b1;
  localparam int   HIST_DEPTH = 4;
  localparam int   SAMPLE_W   = 16;
  localparam int   THRESH_W   = 4;

endpackage

// File: rtl/comp_chan_scheduler_chan_history.sv
// Per-channel sample history shift register, newest sample at index 0.
// win shows the history as it stands after this edge, so a window can be registered on the shift edge itself.
module chan_history #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  shift,
  input  logic [W-1:0]          din,
  output logic [DEPTH-1:0][W-1:0] win
);

  logic [DEPTH-1:0][W-1:0] taps;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      taps <= '0;
    end else if (shift) begin
      taps <= {taps[DEPTH-2:0], din};
    end
  end

  assign win = shift ? {taps[DEPTH-2:0], din} : taps;

endmodule

// File: rtl/comp_chan_scheduler.sv
// Time-multiplexes one compression core across left/right: accept a pair, issue L then R windows,
// collect both results CORE_LAT cycles later and hold the pair (in_ready low) until downstream takes it.
module comp_chan_scheduler
  import comp_sched_pkg::*;
#(
  parameter int CORE_LAT = 0,
  parameter int DEPTH    = HIST_DEPTH
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                in_ready,
  input  logic                cfg_wr,
  input  logic                cfg_chan,
  input  logic [THRESH_W-1:0] cfg_thresh,
  output logic                core_issue,
  output logic                core_chan,
  output logic [SAMPLE_W-1:0] core_win_a,
  output logic [SAMPLE_W-1:0] core_win_b,
  output logic [SAMPLE_W-1:0] core_win_c,
  output logic [SAMPLE_W-1:0] core_win_d,
  output logic [THRESH_W-1:0] core_thresh,
  input  logic [SAMPLE_W-1:0] core_out,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  input  logic                out_ready,
  output logic                out_primed
);

  localparam logic [2:0] LAT_L    = 3'(CORE_LAT);
  localparam logic [2:0] LAT_R    = 3'(CORE_LAT + 1);
  localparam logic [2:0] FILL_MAX = 3'(DEPTH);

  state_t state, state_nxt;
  logic   accept;
  logic   busy;
  logic [2:0] lat_cnt;
  logic [2:0] fill_cnt;
  logic [THRESH_W-1:0] pend_l, pend_r, act_r;
  logic [THRESH_W-1:0] pend_l_nxt, pend_r_nxt;
  logic [DEPTH-1:0][SAMPLE_W-1:0] win_l, win_r;

  assign accept = in_valid & in_ready;
  assign busy   = (state == ISSUE_L) || (state == ISSUE_R) || (state == DRAIN);

  // A write on the acceptance edge must reach the pair being accepted.
  assign pend_l_nxt = (cfg_wr && cfg_chan == CHAN_L) ? cfg_thresh : pend_l;
  assign pend_r_nxt = (cfg_wr && cfg_chan == CHAN_R) ? cfg_thresh : pend_r;

  assign out_primed = (fill_cnt == FILL_MAX);

  chan_history #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_hist_l (
    .clk   (clk),
    .clr_n (n_rst),
    .shift (accept),
    .din   (in_left),
    .win   (win_l)
  );

  chan_history #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_hist_r (
    .clk   (clk),
    .clr_n (n_rst),
    .shift (accept),
    .din   (in_right),
    .win   (win_r)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE_L;
      end
      ISSUE_L: state_nxt = ISSUE_R;
      ISSUE_R: state_nxt = (CORE_LAT > 0) ? DRAIN : HOLD;
      DRAIN:   if (lat_cnt == LAT_R) state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // lat_cnt counts cycles since ISSUE_L; left result lands at CORE_LAT, right one cycle later.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      lat_cnt     <= '0;
      fill_cnt    <= '0;
      pend_l      <= '0;
      pend_r      <= '0;
      act_r       <= '0;
      out_left    <= '0;
      out_right   <= '0;
      core_issue  <= 1'b0;
      core_chan   <= CHAN_L;
      core_win_a  <= '0;
      core_win_b  <= '0;
      core_win_c  <= '0;
      core_win_d  <= '0;
      core_thresh <= '0;
    end else begin
      pend_l <= pend_l_nxt;
      pend_r <= pend_r_nxt;

      if (accept) begin
        act_r <= pend_r_nxt;
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 3'd1;
      end

      if (accept)    lat_cnt <= '0;
      else if (busy) lat_cnt <= lat_cnt + 3'd1;

      if (busy && lat_cnt == LAT_L) out_left  <= core_out;
      if (busy && lat_cnt == LAT_R) out_right <= core_out;

      // The left active threshold is only ever consumed here, on the acceptance edge.
      if (accept) begin
        core_issue  <= 1'b1;
        core_chan   <= CHAN_L;
        core_win_a  <= win_l[0];
        core_win_b  <= win_l[1];
        core_win_c  <= win_l[2];
        core_win_d  <= win_l[3];
        core_thresh <= pend_l_nxt;
      end else if (state == ISSUE_L) begin
        core_chan   <= CHAN_R;
        core_win_a  <= win_r[0];
        core_win_b  <= win_r[1];
        core_win_c  <= win_r[2];
        core_win_d  <= win_r[3];
        core_thresh <= act_r;
      end else if (state == ISSUE_R) begin
        core_issue  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comp_chan_scheduler.sv
// Drives two scheduler instances (core latency 0 and 2) one after the other against a
// transaction-level model: sample queues per channel, pending/active thresholds, accept count.
module tb_comp_chan_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst      [2];
  logic        in_valid   [2];
  logic [15:0] in_left    [2];
  logic [15:0] in_right   [2];
  logic        in_ready   [2];
  logic        cfg_wr     [2];
  logic        cfg_chan   [2];
  logic [3:0]  cfg_thresh [2];
  logic        core_issue [2];
  logic        core_chan  [2];
  logic [15:0] core_win_a [2];
  logic [15:0] core_win_b [2];
  logic [15:0] core_win_c [2];
  logic [15:0] core_win_d [2];
  logic [3:0]  core_thresh[2];
  logic [15:0] core_out   [2];
  logic        out_valid  [2];
  logic [15:0] out_left   [2];
  logic [15:0] out_right  [2];
  logic        out_ready  [2];
  logic        out_primed [2];

  comp_chan_scheduler #(.CORE_LAT(0), .DEPTH(4)) u_dut0 (
    .clk(clk), .n_rst(n_rst[0]), .in_valid(in_valid[0]), .in_left(in_left[0]),
    .in_right(in_right[0]), .in_ready(in_ready[0]), .cfg_wr(cfg_wr[0]), .cfg_chan(cfg_chan[0]),
    .cfg_thresh(cfg_thresh[0]), .core_issue(core_issue[0]), .core_chan(core_chan[0]),
    .core_win_a(core_win_a[0]), .core_win_b(core_win_b[0]), .core_win_c(core_win_c[0]),
    .core_win_d(core_win_d[0]), .core_thresh(core_thresh[0]), .core_out(core_out[0]),
    .out_valid(out_valid[0]), .out_left(out_left[0]), .out_right(out_right[0]),
    .out_ready(out_ready[0]), .out_primed(out_primed[0])
  );

  comp_chan_scheduler #(.CORE_LAT(2), .DEPTH(4)) u_dut1 (
    .clk(clk), .n_rst(n_rst[1]), .in_valid(in_valid[1]), .in_left(in_left[1]),
    .in_right(in_right[1]), .in_ready(in_ready[1]), .cfg_wr(cfg_wr[1]), .cfg_chan(cfg_chan[1]),
    .cfg_thresh(cfg_thresh[1]), .core_issue(core_issue[1]), .core_chan(core_chan[1]),
    .core_win_a(core_win_a[1]), .core_win_b(core_win_b[1]), .core_win_c(core_win_c[1]),
    .core_win_d(core_win_d[1]), .core_thresh(core_thresh[1]), .core_out(core_out[1]),
    .out_valid(out_valid[1]), .out_left(out_left[1]), .out_right(out_right[1]),
    .out_ready(out_ready[1]), .out_primed(out_primed[1])
  );

  // Core stand-in: result is the oldest window sample, delayed by the core latency.
  logic [15:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= core_win_d[1];
    pipe2 <= pipe1;
  end
  assign core_out[0] = core_win_d[0];
  assign core_out[1] = pipe2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ql[$];
  logic [15:0] qr[$];
  logic [3:0]  pend[2];
  logic [3:0]  act[2];
  int          acc_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] win(input bit c, input int i);
    int n;
    n = c ? qr.size() : ql.size();
    if (i >= n) return 16'h0;
    return c ? qr[n-1-i] : ql[n-1-i];
  endfunction

  task automatic model_reset();
    ql.delete();
    qr.delete();
    pend[0] = 4'h0; pend[1] = 4'h0;
    act[0]  = 4'h0; act[1]  = 4'h0;
    acc_cnt = 0;
  endtask

  task automatic reset_dut(input int k);
    n_rst[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst[k] = 1'b1;
    model_reset();
  endtask

  task automatic cfg_idle(input int k, input bit c, input logic [3:0] t);
    cfg_wr[k] = 1'b1; cfg_chan[k] = c; cfg_thresh[k] = t;
    @(negedge clk);
    cfg_wr[k] = 1'b0;
    pend[c] = t;
  endtask

  // Entered and left on a negedge.
  task automatic do_pair(input int k, input logic [15:0] l, input logic [15:0] r,
                         input bit cfg_acc, input bit cfg_c, input logic [3:0] cfg_t,
                         input bit mid_wr, input logic [3:0] mid_t,
                         input int stall, input bit abort);
    logic [15:0] ewl[4];
    logic [15:0] ewr[4];
    int waited;
    int lat;
    lat = (k == 0) ? 0 : 2;
    in_valid[k] = 1'b1; in_left[k] = l; in_right[k] = r;
    cfg_wr[k] = cfg_acc; cfg_chan[k] = cfg_c; cfg_thresh[k] = cfg_t;
    waited = 0;
    while (in_ready[k] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready[k] !== 1'b1) begin
      check("accept_timeout", 0, 1);
      in_valid[k] = 1'b0; cfg_wr[k] = 1'b0;
      return;
    end
    @(posedge clk);
    if (cfg_acc) pend[cfg_c] = cfg_t;
    act = pend;
    ql.push_back(l);
    qr.push_back(r);
    acc_cnt++;
    for (int i = 0; i < 4; i++) begin
      ewl[i] = win(1'b0, i);
      ewr[i] = win(1'b1, i);
    end

    @(negedge clk);
    in_valid[k] = 1'($urandom_range(0, 1));
    in_left[k] = 16'($urandom); in_right[k] = 16'($urandom);
    cfg_wr[k] = 1'b0;
    check("issl_issue", core_issue[k], 1);
    check("issl_chan", core_chan[k], 0);
    check("issl_win_a", core_win_a[k], ewl[0]);
    check("issl_win_b", core_win_b[k], ewl[1]);
    check("issl_win_c", core_win_c[k], ewl[2]);
    check("issl_win_d", core_win_d[k], ewl[3]);
    check("issl_thresh", core_thresh[k], act[0]);
    check("issl_in_ready", in_ready[k], 0);
    check("issl_out_valid", out_valid[k], 0);
    check("issl_primed", out_primed[k], (acc_cnt >= 4) ? 1 : 0);

    @(negedge clk);
    check("issr_issue", core_issue[k], 1);
    check("issr_chan", core_chan[k], 1);
    check("issr_win_a", core_win_a[k], ewr[0]);
    check("issr_win_b", core_win_b[k], ewr[1]);
    check("issr_win_c", core_win_c[k], ewr[2]);
    check("issr_win_d", core_win_d[k], ewr[3]);
    check("issr_thresh", core_thresh[k], act[1]);
    check("issr_in_ready", in_ready[k], 0);

    if (abort) begin
      n_rst[k] = 1'b0;
      @(negedge clk);
      n_rst[k] = 1'b1;
      in_valid[k] = 1'b0;
      model_reset();
      check("abort_out_valid", out_valid[k], 0);
      check("abort_primed", out_primed[k], 0);
      check("abort_in_ready", in_ready[k], 1);
      check("abort_issue", core_issue[k], 0);
      check("abort_out_left", out_left[k], 0);
      return;
    end

    if (mid_wr) begin
      cfg_wr[k] = 1'b1; cfg_chan[k] = 1'b0; cfg_thresh[k] = mid_t;
    end
    @(negedge clk);
    cfg_wr[k] = 1'b0;
    in_valid[k] = 1'b0;
    if (mid_wr) pend[0] = mid_t;
    for (int i = 0; i < lat; i++) begin
      check("drain_out_valid", out_valid[k], 0);
      check("drain_issue", core_issue[k], 0);
      check("drain_in_ready", in_ready[k], 0);
      @(negedge clk);
    end
    check("hold_out_valid", out_valid[k], 1);
    check("hold_out_left", out_left[k], ewl[3]);
    check("hold_out_right", out_right[k], ewr[3]);
    check("hold_in_ready", in_ready[k], 0);
    check("hold_issue", core_issue[k], 0);
    check("hold_core_chan", core_chan[k], 1);
    check("hold_core_win_a", core_win_a[k], ewr[0]);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid[k], 1);
      check("stall_out_left", out_left[k], ewl[3]);
      check("stall_out_right", out_right[k], ewr[3]);
      check("stall_in_ready", in_ready[k], 0);
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check("post_hs_out_valid", out_valid[k], 0);
    check("post_hs_in_ready", in_ready[k], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_rst[k] = 1'b0; in_valid[k] = 1'b0; in_left[k] = '0; in_right[k] = '0;
      cfg_wr[k] = 1'b0; cfg_chan[k] = 1'b0; cfg_thresh[k] = '0; out_ready[k] = 1'b0;
    end
    model_reset();
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      reset_dut(k);
      check("rst_in_ready", in_ready[k], 1);
      check("rst_out_valid", out_valid[k], 0);
      check("rst_primed", out_primed[k], 0);
      check("rst_issue", core_issue[k], 0);
      check("rst_thresh", core_thresh[k], 0);
      check("rst_out_left", out_left[k], 0);
      check("rst_out_right", out_right[k], 0);

      for (int i = 1; i <= 5; i++)
        do_pair(k, 16'(i), 16'(16'h100 + i), 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0);
      check("p5_out_left", out_left[k], 16'h0002);
      check("p5_out_right", out_right[k], 16'h0102);
      check("p5_primed", out_primed[k], 1);

      cfg_idle(k, 1'b0, 4'h5);
      do_pair(k, 16'h1234, 16'hbeef, 1'b1, 1'b1, 4'hA, 1'b1, 4'h3, 0, 1'b0);
      do_pair(k, 16'h8000, 16'h7fff, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 5, 1'b0);

      for (int n = 0; n < 12; n++)
        do_pair(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                4'($urandom), $urandom_range(0, 3), 1'b0);

      do_pair(k, 16'h0aaa, 16'h0bbb, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b1);
      do_pair(k, 16'h0ccc, 16'h0ddd, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
